fetch_ctrl: RTL and testbench
=============================

# fetch_ctrl

Instruction-fetch sequencer for the MIPS core. It owns the program counter and drives the word-indexed, combinational-read `inst_mem` address port. Fetched `{pc, instruction}` pairs go into a 2-entry buffer, which feeds decode through a valid/ready handshake. It also handles branch/jump redirects (flush plus PC reload) and a halt request.

## Interface
Parameters:
- `RESET_PC`, 32'h0000_0000: byte address of the first fetch after reset.
- `DEPTH`, 2: output buffer entries. Fixed at 2; other values are unsupported.

Ports:
- `clk`  in  1  sole clock, rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `mem_addr`  out  32  word index to `inst_mem`; equals `{2'b00, pc[31:2]}`.
- `mem_data`  in  32  instruction word from `inst_mem`, valid in the same cycle as `mem_addr`.
- `out_valid`  out  1  buffer head holds an instruction.
- `out_ready`  in  1  decode accepts the head this cycle.
- `out_inst`  out  32  head instruction.
- `out_pc`  out  32  byte PC of the head instruction.
- `redirect_valid`  in  1  branch/jump taken; flush and reload PC.
- `redirect_pc`  in  32  new byte PC; bits [1:0] are ignored and treated as 0.
- `halt_req`  in  1  stop fetching (e.g. break/syscall).
- `halted`  out  1  the FSM is in HALT.

## Operation
- FSM states: BOOT, RUN, HALT.
  - BOOT: entered on `rst`. Lasts exactly one cycle, with no fetch. Then goes to RUN.
  - RUN: fetches when the push condition holds.
    - `halt_req` with no redirect: go to HALT. No push that cycle.
  - HALT: no fetch. Buffer contents remain poppable.
    - `redirect_valid`: go to RUN.
    - `halt_req` in HALT: no effect.
- Push condition: state is RUN, `!redirect_valid`, `!halt_req`, and (`count < 2` or pop this cycle).
  - A push writes `{pc, mem_data}` to the tail and sets `pc <= pc + 4`.
  - PC arithmetic is mod 2^32; 32'hFFFF_FFFC + 4 wraps to 0.
- Pop: `out_valid && out_ready`. Removes the head.
- Simultaneous push and pop:
  - When full: count stays 2.
  - When count is 1: count stays 1, and the new entry becomes head next cycle.
- Redirect (any state except BOOT):
  - `pc <= {redirect_pc[31:2], 2'b00}`.
  - The buffer is cleared at the clock edge, and there is no push that cycle.
  - A head popped in the same cycle counts as consumed.
  - Redirect overrides `halt_req`.
- Redirect during BOOT is ignored.
- `mem_addr` always reflects the current `pc`, including while stalled or halted.
- Reset values:
  - `pc = RESET_PC`, `count = 0`, state BOOT.
  - `out_valid = 0`, `out_inst = 0`, `out_pc = 0`, `halted = 0`.
  - `mem_addr = RESET_PC >> 2`.
- Reset mid-operation: all buffered entries are discarded and no pop is reported that cycle.

## Timing
- `rst` is sampled high at edge E0. Edge E1 ends BOOT. At E2 the first push (PC = `RESET_PC`) is captured, and `out_valid` is high after E2.
- Fetch-to-output latency: 1 cycle. Entry pushed at edge N is visible after edge N.
- Throughput: 1 instruction/cycle while `out_ready` is held high.
- Redirect asserted in cycle C:
  - `out_valid` is low in cycle C+1.
  - The first instruction at the target is pushed at the end of C+1 and visible in C+2.
- `halted` rises in the cycle after HALT is entered, and falls the cycle after the redirect.
- `out_inst` and `out_pc` must hold stable while `out_valid && !out_ready`.

## Structure
- Shared package `mips_pkg` holds:
  - `fetch_state_t` (BOOT/RUN/HALT).
  - The `INST_W`/`ADDR_W` = 32 constants.
  - The `PC_STEP` = 4 constant.
- Natural sub-module: `fetch_buf`, a 2-entry synchronous FIFO carrying `{pc, inst}`. Its ports are push, pop, flush, full, empty, and head.
- `fetch_ctrl` contains the PC register, the FSM, and the push/redirect logic. `inst_mem` is instantiated outside, in the fetch stage top.

## Test plan
- Reset then stream (`inst_mem` preloaded with word[i]=i, `out_ready`=1):
  - `out_valid` first high 2 cycles after reset release, with `out_pc`=0 and `out_inst`=0.
  - Then `out_pc`=4, 8, 12 with `out_inst`=1, 2, 3 on consecutive cycles.
- Back-pressure: hold `out_ready`=0 for 5 cycles after the first valid.
  - count saturates at 2 and `mem_addr` holds at 2.
  - `out_pc`/`out_inst` stay 0.
  - On release, the entries drain in order 0, 4, then 8 with no gap.
- Redirect with a full buffer: issue `redirect_pc`=32'h40.
  - Next cycle `out_valid`=0.
  - The following cycle `out_pc`=32'h40 and `out_inst`=16.
  - No stale entry appears.
- Misaligned redirect: `redirect_pc`=32'h43 gives `out_pc`=32'h40 and `mem_addr`=16.
- Halt: assert `halt_req` with `out_ready`=1.
  - `halted`=1 next cycle; `out_valid` drops once the buffer empties; no further PC advance.
  - `halt_req` and `redirect_valid` together (target 32'h20): no halt, and fetch resumes at 8.
- Wrap and mid-run reset:
  - Redirect to 32'hFFFF_FFFC gives `out_pc` sequence FFFF_FFFC then 0.
  - Asserting `rst` with 2 entries buffered gives `out_valid`=0 and `mem_addr`=0 next cycle.

Source files
------------

// File: rtl/mips_pkg.sv
// rtl/mips_pkg.sv - shared MIPS core types and constants
// Holds the fetch FSM state type, datapath widths and the PC increment.
package mips_pkg;

   localparam int INST_W = 32;
   localparam int ADDR_W = 32;

   // Byte distance between consecutive instruction words.
   localparam logic [ADDR_W-1:0] PC_STEP = 32'd4;

   typedef enum logic [1:0] {
      BOOT = 2'd0,
      RUN  = 2'd1,
      HALT = 2'd2
   } fetch_state_t;

   // Instruction fetches are word aligned; the low two byte-address bits are dropped.
   function automatic logic [ADDR_W-1:0] align_pc(input logic [ADDR_W-1:0] addr);
      return addr & ~(ADDR_W'(3));
   endfunction

endpackage

// File: rtl/fetch_buf.sv
// rtl/fetch_buf.sv - two-entry {pc, inst} FIFO between fetch and decode
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   push, push_pc/inst  write a new entry at the tail
//   pop                 remove the head (ignored when empty)
//   flush               discard every entry (wins over push and pop)
//   full, empty         occupancy flags
//   head_pc, head_inst  current head entry
module fetch_buf
   import mips_pkg::*;
#(
   parameter int DEPTH = 2
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              push,
   input  logic [ADDR_W-1:0] push_pc,
   input  logic [INST_W-1:0] push_inst,
   input  logic              pop,
   input  logic              flush,
   output logic              full,
   output logic              empty,
   output logic [ADDR_W-1:0] head_pc,
   output logic [INST_W-1:0] head_inst
);

   localparam int CNT_W = $clog2(DEPTH + 1);

   // Slot 0 is always the head; slot 1 is only meaningful when count is 2.
   logic [ADDR_W-1:0] pc0, pc1;
   logic [INST_W-1:0] inst0, inst1;
   logic [CNT_W-1:0]  count;
   logic              do_pop, do_push;

   assign empty     = (count == '0);
   assign full      = (count == CNT_W'(DEPTH));
   assign do_pop    = pop && !empty;
   // A full buffer still accepts a push when the head leaves in the same cycle.
   assign do_push   = push && (!full || do_pop);
   assign head_pc   = pc0;
   assign head_inst = inst0;

   always_ff @(posedge clk) begin
      if (rst) begin
         count <= '0;
         pc0   <= '0;
         pc1   <= '0;
         inst0 <= '0;
         inst1 <= '0;
      end else if (flush) begin
         count <= '0;
      end else begin
         case ({do_push, do_pop})
            2'b10: begin
               if (count == '0) begin
                  pc0   <= push_pc;
                  inst0 <= push_inst;
               end else begin
                  pc1   <= push_pc;
                  inst1 <= push_inst;
               end
               count <= count + CNT_W'(1);
            end
            2'b01: begin
               pc0   <= pc1;
               inst0 <= inst1;
               count <= count - CNT_W'(1);
            end
            2'b11: begin
               // Occupancy is unchanged; the new entry lands behind whatever remains.
               if (count == CNT_W'(1)) begin
                  pc0   <= push_pc;
                  inst0 <= push_inst;
               end else begin
                  pc0   <= pc1;
                  inst0 <= inst1;
                  pc1   <= push_pc;
                  inst1 <= push_inst;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: rtl/fetch_ctrl.sv
// rtl/fetch_ctrl.sv - instruction fetch sequencer: PC, FSM, redirect and halt
// Ports:
//   clk, rst                   clock, synchronous active-high reset
//   mem_addr, mem_data         word-indexed combinational instruction memory port
//   out_valid/ready/inst/pc    head of the fetch buffer towards decode
//   redirect_valid/pc          taken branch/jump: flush buffer and reload PC
//   halt_req, halted           stop fetching / FSM is in HALT
module fetch_ctrl
   import mips_pkg::*;
#(
   parameter logic [31:0] RESET_PC = 32'h0000_0000,
   parameter int          DEPTH    = 2
) (
   input  logic        clk,
   input  logic        rst,
   output logic [31:0] mem_addr,
   input  logic [31:0] mem_data,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [31:0] out_inst,
   output logic [31:0] out_pc,
   input  logic        redirect_valid,
   input  logic [31:0] redirect_pc,
   input  logic        halt_req,
   output logic        halted
);

   fetch_state_t      state_q, state_d;
   logic [ADDR_W-1:0] pc_q;
   logic              push, pop, redirect_take;
   logic              buf_full, buf_empty;

   assign mem_addr  = pc_q >> 2;
   assign out_valid = !buf_empty;
   assign pop       = out_valid && out_ready;
   assign halted    = (state_q == HALT);

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= BOOT;
      end else begin
         state_q <= state_d;
      end
   end

   // Redirect outranks halt; neither a redirect nor a halt cycle fetches.
   always_comb begin
      state_d       = state_q;
      push          = 1'b0;
      redirect_take = 1'b0;
      case (state_q)
         BOOT: begin
            state_d = RUN;
         end
         RUN: begin
            if (redirect_valid) begin
               redirect_take = 1'b1;
            end else if (halt_req) begin
               state_d = HALT;
            end else begin
               push = !buf_full || pop;
            end
         end
         HALT: begin
            if (redirect_valid) begin
               redirect_take = 1'b1;
               state_d       = RUN;
            end
         end
         default: begin
            state_d = BOOT;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         pc_q <= RESET_PC;
      end else if (redirect_take) begin
         pc_q <= align_pc(redirect_pc);
      end else if (push) begin
         pc_q <= pc_q + PC_STEP;
      end
   end

   fetch_buf #(
      .DEPTH(DEPTH)
   ) u_buf (
      .clk      (clk),
      .rst      (rst),
      .push     (push),
      .push_pc  (pc_q),
      .push_inst(mem_data),
      .pop      (pop),
      .flush    (redirect_take),
      .full     (buf_full),
      .empty    (buf_empty),
      .head_pc  (out_pc),
      .head_inst(out_inst)
   );

endmodule

// File: tb/tb_fetch_ctrl.sv
// tb/tb_fetch_ctrl.sv - scoreboard bench for fetch_ctrl
module tb_fetch_ctrl;

   logic        clk = 1'b0;
   logic        rst;
   logic [31:0] mem_addr;
   logic [31:0] mem_data;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] out_inst;
   logic [31:0] out_pc;
   logic        redirect_valid;
   logic [31:0] redirect_pc;
   logic        halt_req;
   logic        halted;

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] inst;
   } exp_t;

   exp_t expq[$];
   int   n_checks = 0;
   int   n_fail   = 0;

   always #5 clk = ~clk;

   // inst_mem preloaded with word[i] = i
   assign mem_data = mem_addr;

   fetch_ctrl #(
      .RESET_PC(32'h0000_0000),
      .DEPTH   (2)
   ) dut (
      .clk           (clk),
      .rst           (rst),
      .mem_addr      (mem_addr),
      .mem_data      (mem_data),
      .out_valid     (out_valid),
      .out_ready     (out_ready),
      .out_inst      (out_inst),
      .out_pc        (out_pc),
      .redirect_valid(redirect_valid),
      .redirect_pc   (redirect_pc),
      .halt_req      (halt_req),
      .halted        (halted)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      n_checks++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s: got %h, required %h (t=%0t)", name, act, req, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic expect_entry(input logic [31:0] pc, input logic [31:0] inst);
      exp_t e;
      e.pc   = pc;
      e.inst = inst;
      expq.push_back(e);
   endtask

   // Monitor: every accepted head must match the next scoreboard entry.
   always @(negedge clk) begin
      if (!rst && out_valid && out_ready) begin
         if (expq.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL unexpected_pop: got pc=%h inst=%h, required no output", out_pc, out_inst);
         end else begin
            exp_t e;
            e = expq.pop_front();
            chk("pop_pc", out_pc, e.pc);
            chk("pop_inst", out_inst, e.inst);
         end
      end
   end

   // Holds rst over two edges, checks reset values, then releases just after edge E0.
   task automatic reset_dut();
      rst            = 1'b1;
      redirect_valid = 1'b0;
      redirect_pc    = 32'h0;
      halt_req       = 1'b0;
      tick();
      @(negedge clk);
      chk("rst_out_valid", {31'b0, out_valid}, 32'd0);
      chk("rst_out_inst", out_inst, 32'h0);
      chk("rst_out_pc", out_pc, 32'h0);
      chk("rst_halted", {31'b0, halted}, 32'd0);
      chk("rst_mem_addr", mem_addr, 32'h0);
      tick();
      rst = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout, required end of test");
      $fatal(1, "watchdog expired");
   end

   initial begin
      out_ready = 1'b1;

      // Reset then stream.
      reset_dut();
      expect_entry(32'd0, 32'd0);
      expect_entry(32'd4, 32'd1);
      expect_entry(32'd8, 32'd2);
      expect_entry(32'd12, 32'd3);
      @(negedge clk);
      chk("boot_valid", {31'b0, out_valid}, 32'd0);
      tick();
      @(negedge clk);
      chk("run1_valid", {31'b0, out_valid}, 32'd0);
      tick();
      @(negedge clk);
      chk("first_valid", {31'b0, out_valid}, 32'd1);
      chk("first_pc", out_pc, 32'd0);
      for (int i = 0; i < 4; i++) tick();
      chk("stream_drain", expq.size(), 32'd0);

      // Back-pressure.
      out_ready = 1'b0;
      reset_dut();
      tick();
      tick();
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         chk("bp_valid", {31'b0, out_valid}, 32'd1);
         chk("bp_pc", out_pc, 32'd0);
         chk("bp_inst", out_inst, 32'd0);
         if (i > 0) chk("bp_mem_addr", mem_addr, 32'd2);
         tick();
      end
      expect_entry(32'd0, 32'd0);
      expect_entry(32'd4, 32'd1);
      expect_entry(32'd8, 32'd2);
      out_ready = 1'b1;
      tick();
      tick();
      tick();
      out_ready = 1'b0;
      chk("bp_drain", expq.size(), 32'd0);
      tick();

      // Redirect with a full buffer (12 and 16 buffered, never delivered).
      redirect_valid = 1'b1;
      redirect_pc    = 32'h40;
      expect_entry(32'h40, 32'd16);
      expect_entry(32'h44, 32'd17);
      tick();
      redirect_valid = 1'b0;
      out_ready      = 1'b1;
      @(negedge clk);
      chk("redir_bubble_valid", {31'b0, out_valid}, 32'd0);
      tick();
      @(negedge clk);
      chk("redir_target_pc", out_pc, 32'h40);
      tick();

      // Misaligned redirect while the head (0x44) is popped this cycle.
      redirect_valid = 1'b1;
      redirect_pc    = 32'h43;
      expect_entry(32'h40, 32'd16);
      tick();
      redirect_valid = 1'b0;
      @(negedge clk);
      chk("mis_bubble_valid", {31'b0, out_valid}, 32'd0);
      chk("mis_mem_addr", mem_addr, 32'd16);
      tick();
      @(negedge clk);
      chk("mis_out_pc", out_pc, 32'h40);
      tick();
      chk("mis_drain", expq.size(), 32'd0);

      // Halt: head 0x44 still drains, PC stays at 0x48.
      halt_req = 1'b1;
      expect_entry(32'h44, 32'd17);
      tick();
      halt_req = 1'b0;
      @(negedge clk);
      chk("halt_halted", {31'b0, halted}, 32'd1);
      chk("halt_valid", {31'b0, out_valid}, 32'd0);
      chk("halt_mem_addr", mem_addr, 32'd18);
      tick();
      @(negedge clk);
      chk("halt_halted2", {31'b0, halted}, 32'd1);
      chk("halt_mem_addr2", mem_addr, 32'd18);
      tick();

      // Halt plus redirect while halted: resume at 0x20.
      halt_req       = 1'b1;
      redirect_valid = 1'b1;
      redirect_pc    = 32'h20;
      expect_entry(32'h20, 32'd8);
      expect_entry(32'h24, 32'd9);
      tick();
      halt_req       = 1'b0;
      redirect_valid = 1'b0;
      @(negedge clk);
      chk("resume_halted", {31'b0, halted}, 32'd0);
      chk("resume_valid", {31'b0, out_valid}, 32'd0);
      tick();
      tick();

      // Halt plus redirect while running, to the top of the address space.
      halt_req       = 1'b1;
      redirect_valid = 1'b1;
      redirect_pc    = 32'hFFFF_FFFC;
      expect_entry(32'hFFFF_FFFC, 32'h3FFF_FFFF);
      expect_entry(32'h0, 32'h0);
      tick();
      halt_req       = 1'b0;
      redirect_valid = 1'b0;
      @(negedge clk);
      chk("wrap_halted", {31'b0, halted}, 32'd0);
      chk("wrap_valid", {31'b0, out_valid}, 32'd0);
      tick();
      @(negedge clk);
      chk("wrap_mem_addr", mem_addr, 32'd0);
      tick();
      tick();
      out_ready = 1'b0;
      tick();
      @(negedge clk);
      chk("fill_valid", {31'b0, out_valid}, 32'd1);
      chk("fill_pc", out_pc, 32'd4);
      tick();
      chk("wrap_drain", expq.size(), 32'd0);

      // Mid-run reset with two entries buffered.
      reset_dut();
      chk("final_drain", expq.size(), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
